jk_mod_counter: RTL and testbench



---
 rtl/jkc_pkg.sv | 22 ++
 rtl/jk_cell.sv | 21 ++
 rtl/jk_mod_counter.sv | 109 ++++++++++
 tb/tb_jk_mod_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jkc_pkg.sv
// Shared definitions for the JK-cell modulo counter: JK excitation codes and
// the JK next-state rule.
package jkc_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Next state of one JK cell given its current state and {J,K}.
    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic nq;
        unique case (jk)
            JK_HOLD:   nq = q;
            JK_CLEAR:  nq = 1'b0;
            JK_SET:    nq = 1'b1;
            default:   nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with asynchronous active-high reset to 0.
module jk_cell
    import jkc_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic J,
    input  logic K,
    output logic Q
);

    // State update: reset clears, otherwise apply the JK rule.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q <= 1'b0;
        end else begin
            Q <= jk_next(Q, {J, K});
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from JK cells. The top level holds only the
// excitation logic, the terminal-count flag and the registered wrap pulse.
// Optional parallel load is enabled by defining JKC_PARALLEL_LOAD_EN.
module jk_mod_counter
    import jkc_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
`ifdef JKC_PARALLEL_LOAD_EN
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MOD - 1);

    logic             load;
    logic [WIDTH-1:0] load_data;

`ifdef JKC_PARALLEL_LOAD_EN
    assign load      = LOAD;
    assign load_data = D;
`else
    assign load      = 1'b0;
    assign load_data = '0;
`endif

    logic [WIDTH-1:0]      up_t;
    logic [WIDTH-1:0]      dn_t;
    logic [WIDTH-1:0][1:0] jk;

    // Toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic cu;
        logic cd;
        cu = 1'b1;
        cd = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            up_t[i] = cu;
            dn_t[i] = cd;
            cu      = cu & Q[i];
            cd      = cd & ~Q[i];
        end
    end

    // Per-cell JK excitation; Q >= QMAX going up covers illegal states too.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            jk[i] = JK_HOLD;
        end
        if (load) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                jk[i] = load_data[i] ? JK_SET : JK_CLEAR;
            end
        end else if (EN) begin
            if (UP) begin
                if (Q >= QMAX) begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        jk[i] = Q[i] ? JK_CLEAR : JK_HOLD;
                    end
                end else begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        jk[i] = up_t[i] ? JK_TOGGLE : JK_HOLD;
                    end
                end
            end else begin
                if (Q == '0) begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        jk[i] = QMAX[i] ? JK_SET : JK_HOLD;
                    end
                end else begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        jk[i] = dn_t[i] ? JK_TOGGLE : JK_HOLD;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        jk_cell u_cell (
            .CLK   (CLK),
            .RESET (RESET),
            .J     (jk[g][1]),
            .K     (jk[g][0]),
            .Q     (Q[g])
        );
    end

    assign TC = EN & ~load & ((UP & (Q == QMAX)) | (~UP & (Q == '0)));

    // Wrap pulse: registered copy of TC, so it is high the cycle after a wrap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= TC;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: a MOD=10 and a MOD=16 instance share
// all inputs and are compared against an arithmetic reference model.
module tb_jk_mod_counter;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q10, q16;
    logic       tc10, tc16, wrap10, wrap16;

    int n_checks = 0;
    int n_fail   = 0;
    int m10 = 0, m16 = 0;
    int w10 = 0, w16 = 0;
    int wrap_cnt;

    always #5 CLK = ~CLK;

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
        .CLK   (CLK),
        .RESET (rst),
        .EN    (en),
        .UP    (up),
`ifdef JKC_PARALLEL_LOAD_EN
        .LOAD  (load),
        .D     (d),
`endif
        .Q     (q10),
        .TC    (tc10),
        .WRAP  (wrap10)
    );

    jk_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
        .CLK   (CLK),
        .RESET (rst),
        .EN    (en),
        .UP    (up),
`ifdef JKC_PARALLEL_LOAD_EN
        .LOAD  (load),
        .D     (d),
`endif
        .Q     (q16),
        .TC    (tc16),
        .WRAP  (wrap16)
    );

    function automatic int model_tc(input int m, input int mod);
        if (load || !en) return 0;
        if (up) return (m == mod - 1) ? 1 : 0;
        return (m == 0) ? 1 : 0;
    endfunction

    function automatic int model_next(input int m, input int mod);
        if (load) return int'(d);
        if (!en) return m;
        if (up) return (m >= mod - 1) ? 0 : m + 1;
        return (m == 0) ? mod - 1 : m - 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " q10"},    {28'd0, q10},    m10);
        check({tag, " wrap10"}, {31'd0, wrap10}, w10);
        check({tag, " tc10"},   {31'd0, tc10},   model_tc(m10, 10));
        check({tag, " q16"},    {28'd0, q16},    m16);
        check({tag, " wrap16"}, {31'd0, wrap16}, w16);
        check({tag, " tc16"},   {31'd0, tc16},   model_tc(m16, 16));
    endtask

    // One clock edge with inputs held; model advances, then outputs are checked.
    task automatic tick(input string tag);
        int n10, n16, t10, t16;
        n10 = model_next(m10, 10);
        n16 = model_next(m16, 16);
        t10 = model_tc(m10, 10);
        t16 = model_tc(m16, 16);
        @(posedge CLK);
        #1;
        if (rst) begin
            m10 = 0; m16 = 0; w10 = 0; w16 = 0;
        end else begin
            m10 = n10; m16 = n16; w10 = t10; w16 = t16;
        end
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m10 = 0; m16 = 0; w10 = 0; w16 = 0;
        check_all("reset");
        @(negedge CLK);
        rst = 1'b0;
    endtask

    initial begin
        // 1: async reset mid-count
        @(negedge CLK);
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) tick("t1 up");
        check("t1 q=5", {28'd0, q10}, 32'd5);
        rst = 1'b1;
        #1;
        check("t1 async q", {28'd0, q10}, 32'd0);
        check("t1 async wrap", {31'd0, wrap10}, 32'd0);
        m10 = 0; m16 = 0; w10 = 0; w16 = 0;
        @(negedge CLK);
        rst = 1'b0;
        tick("t1 release");
        check("t1 q=1", {28'd0, q10}, 32'd1);

        // 2: up wrap at MOD=10
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 9; i++) tick("t2 up");
        check("t2 q=9", {28'd0, q10}, 32'd9);
        check("t2 tc", {31'd0, tc10}, 32'd1);
        tick("t2 wrap");
        check("t2 q=0", {28'd0, q10}, 32'd0);
        check("t2 wrap=1", {31'd0, wrap10}, 32'd1);
        tick("t2 after");
        check("t2 wrap=0", {31'd0, wrap10}, 32'd0);

        // 3: down wrap at MOD=10
        do_reset();
        en = 1'b1; up = 1'b0;
        #1;
        check("t3 tc", {31'd0, tc10}, 32'd1);
        tick("t3 wrap");
        check("t3 q=9", {28'd0, q10}, 32'd9);
        check("t3 wrap=1", {31'd0, wrap10}, 32'd1);
        tick("t3 dn");
        check("t3 q=8", {28'd0, q10}, 32'd8);
        tick("t3 dn");
        check("t3 q=7", {28'd0, q10}, 32'd7);
        tick("t3 dn");

        // 4: hold at 6, then alternate direction
        check("t4 q=6", {28'd0, q10}, 32'd6);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("t4 hold");
            check("t4 hold q", {28'd0, q10}, 32'd6);
            check("t4 hold tc", {31'd0, tc10}, 32'd0);
        end
        en = 1'b1;
        up = 1'b1; tick("t4 flip"); check("t4 q=7", {28'd0, q10}, 32'd7);
        up = 1'b0; tick("t4 flip"); check("t4 q=6", {28'd0, q10}, 32'd6);
        up = 1'b1; tick("t4 flip"); check("t4 q=7b", {28'd0, q10}, 32'd7);

        // 5: full modulus, MOD=16
        do_reset();
        en = 1'b1; up = 1'b1;
        wrap_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick("t5 up");
            wrap_cnt += int'(wrap16);
        end
        check("t5 q16=0", {28'd0, q16}, 32'd0);
        check("t5 wraps", wrap_cnt, 32'd1);

`ifdef JKC_PARALLEL_LOAD_EN
        // 6: parallel load
        en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd7;
        tick("t6 load");
        check("t6 q=7", {28'd0, q10}, 32'd7);
        check("t6 wrap", {31'd0, wrap10}, 32'd0);
        d = 4'd9;
        tick("t6 load9");
        check("t6 tc forced", {31'd0, tc10}, 32'd0);
        d = 4'd12;
        tick("t6 illegal");
        load = 1'b0; up = 1'b1;
        tick("t6 illegal up");
        check("t6 illegal->0", {28'd0, q10}, 32'd0);
        load = 1'b1; d = 4'd12;
        tick("t6 illegal2");
        load = 1'b0; up = 1'b0;
        tick("t6 illegal dn");
        check("t6 illegal->11", {28'd0, q10}, 32'd11);
        load = 1'b1; d = 4'd5; rst = 1'b1;
        tick("t6 rst+load");
        check("t6 rst dom", {28'd0, q10}, 32'd0);
        load = 1'b0;
        @(negedge CLK);
        rst = 1'b0;
`endif

        // Random phase against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            up = $urandom_range(0, 1) != 0;
`ifdef JKC_PARALLEL_LOAD_EN
            load = ($urandom_range(0, 7) == 0);
            d = 4'($urandom_range(0, 15));
`endif
            tick("rand");
        end
        load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
